// File: rtl/apb_regfile_p.sv
// rtl/apb_regfile_p.sv - parametrised APB4 slave register file with strobes, wait states and PSLVERR
module apb_regfile_p #(
  parameter int                             DATA_WIDTH   = 32,
  parameter int                             NUM_REGS     = 8,
  parameter int                             ADDR_WIDTH   = 32,
  parameter int                             WAIT_STATES  = 0,
  parameter logic [NUM_REGS-1:0]            RO_MASK      = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB = DATA_WIDTH / 8;
  // Width of the register select; at least one bit so a single-register file still elaborates.
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // Word index is widened to whichever is larger, the bus index or the select, so the
  // range compare never truncates either side.
  localparam int XW = ((ADDR_WIDTH - 2) > IW) ? (ADDR_WIDTH - 2) : IW;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic [XW-1:0] idx_ext;
  logic [IW-1:0] idx_sel;
  logic          in_range;
  logic          misaligned;
  logic          wr_ro;
  logic          err;
  logic          commit_wr;

  // Address decode and error classification for the transfer currently on the bus.
  always_comb begin
    idx_ext    = XW'(PADDR[ADDR_WIDTH-1:2]);
    idx_sel    = idx_ext[IW-1:0];
    in_range   = (idx_ext < XW'(NUM_REGS));
    misaligned = (PADDR[1:0] != 2'b00);
    wr_ro      = PWRITE & in_range & RO_MASK[idx_sel];
    err        = misaligned | ~in_range | wr_ro;
  end

  // PREADY depends only on FSM state and the master's control lines, never on write data.
  assign PREADY    = (state_q == ACCESS) & PSEL & PENABLE & (wait_cnt_q == 4'd0);
  assign PSLVERR   = PREADY & err;
  assign commit_wr = PREADY & PWRITE & ~err;
  assign PRDATA    = (PREADY & ~PWRITE & ~err) ? regs_q[idx_sel] : '0;

  // Next-state and wait-counter logic for the setup/access handshake.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d    = ACCESS;
          wait_cnt_d = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master dropped select mid-transfer: abandon it without committing.
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
        end else if (!PENABLE) begin
          // A new setup phase restarts the transfer from scratch.
          wait_cnt_d = 4'(WAIT_STATES);
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Byte-lane merge of write data into the addressed register.
  always_comb begin
    regs_d = regs_q;
    if (commit_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (PSTRB[b]) begin
          regs_d[idx_sel][8*b +: 8] = PWDATA[8*b +: 8];
        end
      end
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Register storage; read-only entries never load and so keep their reset value.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!RO_MASK[i]) begin
          regs_q[i] <= regs_d[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_p.sv
// tb/tb_apb_regfile_p.sv - directed self-checking bench for apb_regfile_p
module tb_apb_regfile_p;

  localparam logic [255:0] RV = {32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h5A5A_5555, 32'h1234_9876, 32'hA5A5_0000, 32'h0};

  logic        clk;
  logic        rst;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];

  int n_checks;
  int n_errors;

  logic [31:0] rd;
  logic        er;
  int          wt;

  apb_regfile_p #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(32), .WAIT_STATES(0),
                  .RO_MASK(8'b0000_0001), .RESET_VALUES(RV)) dut0 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_regfile_p #(.DATA_WIDTH(32), .NUM_REGS(8), .ADDR_WIDTH(32), .WAIT_STATES(3),
                  .RO_MASK(8'b0000_0001), .RESET_VALUES(RV)) dut3 (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Full transfer; entered and left 1 time unit after a rising edge so calls chain back-to-back.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic serr, output int waits);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    waits = 0;
    rdata = '0;
    serr  = 1'b0;
    forever begin
      @(negedge clk);
      if (pready[d]) break;
      waits++;
      if (waits > 40) begin
        check("xfer_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    rdata = prdata[d];
    serr  = pslverr[d];
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
      paddr[d] = 0; pwdata[d] = 0; pstrb[d] = 0;
    end
    #1;
    check("rst_pready", 32'(pready[0]), 32'd0);
    check("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check("rst_prdata", prdata[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset values, zero wait states
    apb_xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
    check("rd_reg1", rd, 32'hA5A5_0000);
    check("rd_reg1_err", 32'(er), 32'd0);
    check("rd_reg1_waits", 32'(wt), 32'd0);
    apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
    check("rd_reg2", rd, 32'h1234_9876);

    // Byte strobes
    apb_xfer(0, 1'b1, 32'hC, 32'hDEAD_BEEF, 4'b0101, rd, er, wt);
    check("wr_strb_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, wt);
    check("rd_strb", rd, 32'h5AAD_55EF);

    // Errors
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, wt);
    check("oor_err", 32'(er), 32'd1);
    check("oor_data", rd, 32'd0);
    apb_xfer(0, 1'b1, 32'h2, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    check("mis2_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b1, 32'h6, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    check("mis6_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
    check("mis6_nochg", rd, 32'hA5A5_0000);
    apb_xfer(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF, rd, er, wt);
    check("ro_err", 32'(er), 32'd1);
    apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, wt);
    check("ro_rd", rd, 32'd0);
    check("ro_rd_err", 32'(er), 32'd0);

    // Empty strobe commits nothing
    apb_xfer(0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, rd, er, wt);
    check("strb0_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, wt);
    check("strb0_rd", rd, 32'h1234_9876);

    // Back-to-back write then read
    apb_xfer(0, 1'b1, 32'h10, 32'h0000_0042, 4'hF, rd, er, wt);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt);
    check("b2b_rd", rd, 32'h0000_0042);

    // Wait states: read latency
    apb_xfer(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, wt);
    check("ws_waits", 32'(wt), 32'd3);
    check("ws_rd", rd, 32'hA5A5_0000);

    // Wait states: write lands only at the PREADY edge
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 32'h14; pwdata[1] = 32'hCAFE_F00D; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_pready", 32'(pready[1]), 32'd0);
      check("stall_old", dut3.regs_q[5], 32'd0);
    end
    @(negedge clk);
    check("stall_ready", 32'(pready[1]), 32'd1);
    @(posedge clk); #1;
    psel[1] = 0; penable[1] = 0;
    check("stall_new", dut3.regs_q[5], 32'hCAFE_F00D);

    // Abort by dropping PSEL during the stall
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1;
    paddr[1] = 32'h18; pwdata[1] = 32'h1234_5678; pstrb[1] = 4'hF;
    @(posedge clk); #1;
    penable[1] = 1;
    @(posedge clk); #1;
    psel[1] = 0; penable[1] = 0;
    @(negedge clk);
    check("abort_pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    check("abort_idle", 32'(dut3.state_q), 32'd0);
    apb_xfer(1, 1'b0, 32'h18, 32'h0, 4'h0, rd, er, wt);
    check("abort_nocommit", rd, 32'd0);
    check("abort_waits", 32'(wt), 32'd3);

    // Reset asserted mid-access
    psel[0] = 1; penable[0] = 0; pwrite[0] = 0; paddr[0] = 32'h4;
    @(posedge clk); #1;
    penable[0] = 1;
    #1;
    check("pre_rst_rd", prdata[0], 32'hA5A5_0000);
    rst = 1'b1;
    #1;
    check("async_pready", 32'(pready[0]), 32'd0);
    check("async_prdata", prdata[0], 32'd0);
    check("async_pslverr", 32'(pslverr[0]), 32'd0);
    psel[0] = 0; penable[0] = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, wt);
    check("post_rst_reg3", rd, 32'h5A5A_5555);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, wt);
    check("post_rst_reg4", rd, 32'd0);
    apb_xfer(0, 1'b1, 32'h1C, 32'h0BAD_F00D, 4'hF, rd, er, wt);
    apb_xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0, rd, er, wt);
    check("post_rst_wr", rd, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_regfile_p.md
# apb_regfile_p

Parametrised APB4 slave register file that replaces the fixed five-entry, zero-wait-state register bank. It provides a configurable number and width of registers, per-register reset values, and a per-register read-only mask. It also supports byte-lane write strobes, programmable wait states on PREADY, and PSLVERR on illegal accesses. It sits behind the APB bridge as the control/status register block and is the target of the RAL model.

## Interface

Parameters:
- DATA_WIDTH, 32, register and bus data width; multiple of 8, 8..64
- NUM_REGS, 8, number of registers; 1..256
- ADDR_WIDTH, 32, PADDR width
- WAIT_STATES, 0, extra access-phase cycles before PREADY; 0..15
- RO_MASK, 0 (NUM_REGS bits), bit i = 1 makes register i read-only
- RESET_VALUES, 0 (NUM_REGS*DATA_WIDTH bits), register i reset value in bits [i*DATA_WIDTH +: DATA_WIDTH]

Ports:
- PCLK  in  1  clock; all state changes on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  byte-lane write enables
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completion
- PSLVERR  out  1  transfer error, valid only with PREADY

## Operation

- Decode: index = PADDR[ADDR_WIDTH-1:2] (word addressing, 4-byte stride regardless of DATA_WIDTH).
- The transfer has an error (err) on any of:
  - PADDR[1:0] != 0
  - index >= NUM_REGS
  - write to a register with its RO_MASK bit set
- FSM states:
  - IDLE: on PSEL & !PENABLE (setup phase), go to ACCESS and load wait_cnt <= WAIT_STATES. Otherwise stay.
  - ACCESS, !PSEL: abort to IDLE with no commit and wait_cnt <= 0 (protocol violation).
  - ACCESS, PSEL & PENABLE & wait_cnt != 0: decrement wait_cnt and stay.
  - ACCESS, PSEL & PENABLE & wait_cnt == 0: complete the transfer and go to IDLE.
  - ACCESS, PSEL & !PENABLE: treat as a fresh setup; reload wait_cnt and stay.
- PREADY = (state == ACCESS) & PSEL & PENABLE & (wait_cnt == 0). This is combinational from state; no glitch path from PWDATA.
- Write commit happens at the rising edge where PREADY = 1, PWRITE = 1 and !err. For each lane b with PSTRB[b] = 1, reg[index][8b+7:8b] <= PWDATA[8b+7:8b]. Lanes with PSTRB[b] = 0 are unchanged. PSTRB = 0 is legal and commits nothing.
- Error write: no register changes.
- Read: PRDATA = reg[index] when PREADY & !PWRITE & !err. Otherwise PRDATA = 0. Read-only registers are readable.
- PSLVERR = PREADY & err. On an error read, PRDATA = 0.
- Reads have no side effects. Read-only registers hold their RESET_VALUES entry forever.

## Timing

- Reset (PRESET high, asynchronous):
  - state = IDLE, wait_cnt = 0, reg[i] = RESET_VALUES[i].
  - Consequently PREADY = 0, PSLVERR = 0 and PRDATA = 0 immediately, with no clock required.
- Reset asserted mid-transfer: the transfer is dropped with no commit. After release the FSM is in IDLE and needs a new setup phase.
- Latency:
  - Setup cycle plus access cycles; PREADY rises in access cycle WAIT_STATES+1.
  - WAIT_STATES = 0 gives a classic 2-cycle transfer with PREADY high in the first access cycle.
- A written value is visible to a read whose setup phase starts the cycle after the write completes. Back-to-back transfers are supported with no idle cycle.
- Holding PSEL & PENABLE with PREADY low keeps the slave stalled; all inputs must be held stable (master obligation).

## Test plan

- Reset values: RESET_VALUES reg1 = 32'hA5A5_0000, reg2 = 32'h1234_9876. Read 0x4 -> PRDATA 32'hA5A5_0000; read 0x8 -> 32'h1234_9876; PSLVERR 0.
- Strobes: reg3 = 32'h5A5A_5555. Write 0xC with PWDATA 32'hDEAD_BEEF, PSTRB 4'b0101, then read 0xC -> 32'h5AAD_55EF.
- Wait states: WAIT_STATES = 3. PREADY is low for 3 access cycles and high on the 4th. A write lands only at the PREADY edge; a mid-stall probe shows the old value.
- Errors:
  - Read 0x20 with NUM_REGS = 8 -> PSLVERR 1, PRDATA 0.
  - Write 0x2 (misaligned) -> PSLVERR 1, no change.
  - Write 32'hFFFF_FFFF to RO reg0 (reset 0) -> PSLVERR 1; reg0 reads back 0.
- Abort/reset: drop PSEL during a wait stall -> no commit, FSM IDLE. Assert PRESET mid-access -> outputs 0 asynchronously, registers back to reset values, next transfer completes normally.
- Back-to-back: write 0x10 = 32'h0000_0042 immediately followed by a read of 0x10 -> read returns 32'h0000_0042 with no idle cycle between transfers.
